glb_arb: RTL and testbench

GLB_ARB -- requirements
Module: glb_arb

---
 rtl/glb_pkg.sv | 21 ++
 rtl/rr_arb.sv | 31 +++
 rtl/glb_arb.sv | 135 +++++++++++++
 tb/tb_glb_arb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/glb_pkg.sv
// Shared types and width helpers for the global-buffer burst arbiter.
package glb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int MAX_BURST_DEF = 16;

    // Length field must hold MAX_BURST itself, hence the extra bit.
    function automatic int calc_len_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    // Index width for a requester vector; never narrower than one bit.
    function automatic int calc_ptr_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin winner search: first asserted request at or after ptr, wrapping.
module rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   idx
);

    int   pos;
    logic found;

    // Scan requesters starting from ptr; the first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[PTR_W'(pos)]) begin
                found             = 1'b1;
                gnt[PTR_W'(pos)]  = 1'b1;
                idx               = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/glb_arb.sv
// Global-buffer burst arbiter: grants one PE-row requester at a time, streams
// its burst of buffer reads and returns the data beats to that requester.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | no burst running; req_ready offered to the round-robin winner
//  BURST | issuing one buffer read per cycle for the latched burst
module glb_arb
    import glb_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_REQ    = 4,
    parameter  int ADDR_WIDTH = 10,
    parameter  int MAX_BURST  = MAX_BURST_DEF,
    localparam int LEN_WIDTH  = calc_len_width(MAX_BURST),
    localparam int PTR_W      = calc_ptr_width(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]    req_len,
    output logic                                 buf_rd_en,
    output logic [ADDR_WIDTH-1:0]                buf_rd_addr,
    input  logic [DATA_WIDTH-1:0]                buf_rd_data,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic                                 rsp_last,
    output logic                                 busy
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BURST);

    state_t                state;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      owner;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] data_hold;

    logic [NUM_REQ-1:0]    gnt;
    logic [PTR_W-1:0]      win_idx;
    logic [LEN_WIDTH-1:0]  sel_len;
    logic [LEN_WIDTH-1:0]  eff_len;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [PTR_W-1:0]      ptr_next;
    logic                  accept;

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (win_idx)
    );

    // Offer and acceptance decode for the current winner.
    always_comb begin
        req_ready = (rstn && state == IDLE) ? gnt : '0;
        accept    = (state == IDLE) && (|req_valid);
        sel_len   = req_len[win_idx];
        sel_addr  = req_addr[win_idx];
        eff_len   = (sel_len > MAX_LEN) ? MAX_LEN : sel_len;
        ptr_next  = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    // Burst sequencer: latches the winning request and walks its read addresses.
    // cnt always holds the number of reads left including the current one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            cnt         <= '0;
            buf_rd_en   <= 1'b0;
            buf_rd_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    buf_rd_en <= 1'b0;
                    if (accept) begin
                        ptr <= ptr_next;
                        // Zero-length requests are consumed without any read.
                        if (eff_len != '0) begin
                            state       <= BURST;
                            owner       <= win_idx;
                            cnt         <= eff_len;
                            buf_rd_en   <= 1'b1;
                            buf_rd_addr <= sel_addr;
                        end
                    end
                end
                BURST: begin
                    if (cnt == LEN_WIDTH'(1)) begin
                        state     <= IDLE;
                        buf_rd_en <= 1'b0;
                    end else begin
                        buf_rd_addr <= buf_rd_addr + ADDR_WIDTH'(1);
                        cnt         <= cnt - LEN_WIDTH'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    buf_rd_en <= 1'b0;
                end
            endcase
        end
    end

    // Response beat strobes trail each read by one cycle; data_hold keeps the
    // last beat so rsp_data stays put between bursts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= '0;
            rsp_last  <= 1'b0;
            data_hold <= '0;
        end else begin
            rsp_valid <= buf_rd_en ? (NUM_REQ'(1) << owner) : '0;
            rsp_last  <= buf_rd_en && (cnt == LEN_WIDTH'(1));
            if (|rsp_valid) begin
                data_hold <= buf_rd_data;
            end
        end
    end

    // The buffer output is already registered inside the SRAM, so the beat is
    // passed straight through while valid to keep read-to-response at one cycle.
    always_comb begin
        rsp_data = (|rsp_valid) ? buf_rd_data : data_hold;
        busy     = (state == BURST);
    end

endmodule

// File: tb/tb_glb_arb.sv
module tb_glb_arb;

    logic             clk;
    logic             rstn;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][9:0]  req_addr;
    logic [3:0][4:0]  req_len;
    logic             buf_rd_en;
    logic [9:0]       buf_rd_addr;
    logic [15:0]      buf_rd_data;
    logic [3:0]       rsp_valid;
    logic [15:0]      rsp_data;
    logic             rsp_last;
    logic             busy;

    int checks = 0;
    int errors = 0;

    glb_arb dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_len     (req_len),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous buffer model: data = addr ^ 0xA5A5, one cycle after the strobe.
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= {6'b0, buf_rd_addr} ^ 16'hA5A5;
    end

    // One requester-masked burst, checked cycle by cycle from acceptance.
    task automatic do_burst(input logic [3:0] mask, input int win,
                            input logic [9:0] a, input int len);
        int          eff;
        logic [9:0]  ad;
        logic [15:0] exp_data;
        eff = (len > 16) ? 16 : len;
        @(negedge clk);
        req_valid = mask;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                req_addr[i] = a;
                req_len[i]  = 5'(len);
            end
        end
        #1;
        checks++;
        if (req_ready !== 4'(1 << win)) begin
            errors++;
            $display("FAIL burst_ready got=%b exp=%b", req_ready, 4'(1 << win));
        end
        for (int c = 1; c <= eff + 1; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 4'b0;
            #1;
            ad = a + 10'(c - 1);
            checks++;
            if (buf_rd_en !== (c <= eff) || busy !== (c <= eff)) begin
                errors++;
                $display("FAIL burst_en cyc=%0d got en=%b busy=%b exp=%b", c, buf_rd_en, busy, (c <= eff));
            end
            if (c <= eff) begin
                checks++;
                if (buf_rd_addr !== ad) begin
                    errors++;
                    $display("FAIL burst_addr cyc=%0d got=%h exp=%h", c, buf_rd_addr, ad);
                end
            end
            checks++;
            if (c >= 2) begin
                ad       = a + 10'(c - 2);
                exp_data = {6'b0, ad} ^ 16'hA5A5;
                if (rsp_valid !== 4'(1 << win) || rsp_data !== exp_data || rsp_last !== (c == eff + 1)) begin
                    errors++;
                    $display("FAIL burst_rsp cyc=%0d got v=%b d=%h l=%b exp v=%b d=%h l=%b",
                             c, rsp_valid, rsp_data, rsp_last, 4'(1 << win), exp_data, (c == eff + 1));
                end
            end else begin
                if (rsp_valid !== 4'b0 || rsp_last !== 1'b0) begin
                    errors++;
                    $display("FAIL burst_rsp_early got v=%b l=%b exp v=0000 l=0", rsp_valid, rsp_last);
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        req_valid = 4'b1111;
        req_addr  = '0;
        req_len   = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0 || buf_rd_en !== 1'b0 || buf_rd_addr !== 10'h0 ||
            rsp_valid !== 4'b0 || rsp_data !== 16'h0 || rsp_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b en=%b a=%h v=%b d=%h l=%b busy=%b exp all zero",
                     req_ready, buf_rd_en, buf_rd_addr, rsp_valid, rsp_data, rsp_last, busy);
        end
        req_valid = 4'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || buf_rd_en !== 1'b0 || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL reset_release got busy=%b en=%b rdy=%b exp 0 0 0000", busy, buf_rd_en, req_ready);
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = 10'(i * 16);
            req_len[i]  = 5'd2;
        end
        for (int g = 0; g < 4; g++) begin
            if (g > 0) @(negedge clk);
            #1;
            checks++;
            if (req_ready !== 4'(1 << g) || buf_rd_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rr_grant g=%0d got rdy=%b en=%b busy=%b exp rdy=%b en=0 busy=0",
                         g, req_ready, buf_rd_en, busy, 4'(1 << g));
            end
            checks++;
            if (rsp_valid !== ((g > 0) ? 4'(1 << (g - 1)) : 4'b0) || rsp_last !== (g > 0)) begin
                errors++;
                $display("FAIL rr_prev_last g=%0d got v=%b l=%b", g, rsp_valid, rsp_last);
            end
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                #1;
                checks++;
                if (req_ready !== 4'b0 || buf_rd_en !== 1'b1 || buf_rd_addr !== 10'(g * 16 + k)) begin
                    errors++;
                    $display("FAIL rr_read g=%0d k=%0d got rdy=%b en=%b a=%h exp rdy=0000 en=1 a=%h",
                             g, k, req_ready, buf_rd_en, buf_rd_addr, 10'(g * 16 + k));
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0001 || rsp_valid !== 4'b1000 || rsp_last !== 1'b1) begin
            errors++;
            $display("FAIL rr_wrap got rdy=%b v=%b l=%b exp rdy=0001 v=1000 l=1", req_ready, rsp_valid, rsp_last);
        end
        // Withdrawn before the edge: must be dropped.
        req_valid = 4'b0;
        @(negedge clk);
        #1;
        checks++;
        if (buf_rd_en !== 1'b0 || busy !== 1'b0 || rsp_valid !== 4'b0) begin
            errors++;
            $display("FAIL rr_drop got en=%b busy=%b v=%b exp 0 0 0000", buf_rd_en, busy, rsp_valid);
        end
    endtask

    task automatic test_single();
        do_burst(4'b0001, 0, 10'h010, 4);
    endtask

    task automatic test_len_zero();
        // ptr is 1 here; a zero-length request from 1 must still advance it to 2.
        do_burst(4'b0010, 1, 10'h055, 0);
        @(negedge clk);
        #1;
        checks++;
        if (buf_rd_en !== 1'b0 || busy !== 1'b0 || rsp_valid !== 4'b0) begin
            errors++;
            $display("FAIL len0_quiet got en=%b busy=%b v=%b exp 0 0 0000", buf_rd_en, busy, rsp_valid);
        end
        do_burst(4'b0110, 2, 10'h020, 1);
    endtask

    task automatic test_wrap();
        do_burst(4'b1000, 3, 10'h3FE, 4);
    endtask

    task automatic test_len_max();
        do_burst(4'b0010, 1, 10'h200, 20);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid   = 4'b0100;
        req_addr[2] = 10'h100;
        req_len[2]  = 5'd8;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rstmid_ready got=%b exp=0100", req_ready);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 4'b0;
        end
        #1;
        checks++;
        if (buf_rd_en !== 1'b1 || buf_rd_addr !== 10'h102) begin
            errors++;
            $display("FAIL rstmid_third got en=%b a=%h exp en=1 a=102", buf_rd_en, buf_rd_addr);
        end
        rstn      = 1'b0;
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0 || buf_rd_en !== 1'b0 || buf_rd_addr !== 10'h0 ||
            rsp_valid !== 4'b0 || rsp_data !== 16'h0 || rsp_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_zero got rdy=%b en=%b a=%h v=%b d=%h l=%b busy=%b exp all zero",
                     req_ready, buf_rd_en, buf_rd_addr, rsp_valid, rsp_data, rsp_last, busy);
        end
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rstmid_ptr got rdy=%b exp=0001", req_ready);
        end
        req_valid = 4'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 4'b0 || buf_rd_en !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stray cyc=%0d got v=%b en=%b busy=%b exp 0", c, rsp_valid, buf_rd_en, busy);
            end
        end
    endtask

    task automatic test_random_data();
        int         r;
        int         len;
        logic [9:0] a;
        for (int t = 0; t < 6; t++) begin
            r   = $urandom_range(0, 3);
            len = $urandom_range(1, 16);
            a   = 10'($urandom_range(0, 1023));
            do_burst(4'(1 << r), r, a, len);
        end
    endtask

    initial begin
        buf_rd_data = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_len_zero();
        test_wrap();
        test_len_max();
        test_reset_mid();
        test_random_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
